// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream requesters.
// Ownership is held for a whole packet; each byte is handed over with a one-cycle start pulse.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              err_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARB, SEND, ACK, DONE} state_t;

  state_t        state;
  logic [IW-1:0] last_owner;
  logic          last_flag;
  logic [CW-1:0] ack_cnt;

  logic [IW:0]   arb_cand;
  logic [IW-1:0] arb_idx;
  logic          arb_found;
  logic [7:0]    owner_data;
  logic          owner_last;
  logic          accept;

  // First valid requester at or after last_owner+1, wrapping modulo NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      arb_cand = {1'b0, last_owner} + (IW+1)'(k);
      if (arb_cand >= NREQ_W) arb_cand = arb_cand - NREQ_W;
      if (!arb_found && req_valid[arb_cand[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    owner_data = '0;
    owner_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == last_owner) begin
        owner_data = req_data[8*i +: 8];
        owner_last = req_last[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == SEND && !tx_busy) req_ready = grant & req_valid;
  end

  assign accept = |req_ready;

  // ack_cnt counts ACK cycles from the start pulse; the last count before the limit flags a timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
      last_flag   <= 1'b0;
      ack_cnt     <= '0;
      last_owner  <= IW'(NREQ - 1);
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) state <= ARB;
        end
        ARB: begin
          if (arb_found) begin
            grant      <= NREQ'(1) << arb_idx;
            last_owner <= arb_idx;
            state      <= SEND;
          end else begin
            grant <= '0;
            state <= IDLE;
          end
        end
        SEND: begin
          if (accept) begin
            tx_data   <= owner_data;
            last_flag <= owner_last;
            tx_start  <= 1'b1;
            ack_cnt   <= '0;
            state     <= ACK;
          end
        end
        ACK: begin
          if (tx_busy) begin
            state <= DONE;
          end else if (ack_cnt == ACK_LAST) begin
            err_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!tx_busy) begin
            if (last_flag) begin
              grant <= '0;
              state <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a UART busy model drive the DUT while a
// packet-level round-robin model predicts the order of transmitted bytes.
module tb_uart_tx_arbiter;

  localparam int NREQ        = 4;
  localparam int ACK_TIMEOUT = 15;

  logic              clk         = 1'b0;
  logic              resetn      = 1'b1;
  logic [NREQ-1:0]   req_valid   = '0;
  logic [8*NREQ-1:0] req_data    = '0;
  logic [NREQ-1:0]   req_last    = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy     = 1'b0;
  logic              err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int start_cycle = -1;
  logic [8:0]  drv_q [NREQ][$];
  logic [8:0]  mdl_q [NREQ][$];
  logic [11:0] exp_q [$];
  int mdl_ptr = 0;
  logic [NREQ-1:0] paused = '0;
  logic [7:0] last_tx = 8'h00;
  int busy_delay = 1;
  int busy_len = 10;
  int uart_pend = 0;
  int uart_hold = 0;
  bit uart_never = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    logic [8:0] head;
    for (int i = 0; i < NREQ; i++) begin
      if (drv_q[i].size() > 0) begin
        head = drv_q[i][0];
        req_valid[i]       = !paused[i];
        req_data[8*i +: 8] = head[7:0];
        req_last[i]        = head[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic load_byte(input int r, input logic [7:0] b, input logic last);
    drv_q[r].push_back({last, b});
    mdl_q[r].push_back({last, b});
  endtask

  task automatic load_packet(input int r, input int len);
    for (int b = 0; b < len; b++) load_byte(r, 8'($urandom), b == len - 1);
  endtask

  // Whole packets are granted in round-robin order starting after the previous owner.
  task automatic model_run();
    int owner;
    logic [8:0] e;
    bit done_pkt;
    do begin
      owner = -1;
      for (int k = 0; k < NREQ; k++)
        if (owner < 0 && mdl_q[(mdl_ptr + k) % NREQ].size() > 0) owner = (mdl_ptr + k) % NREQ;
      if (owner >= 0) begin
        done_pkt = 1'b0;
        while (!done_pkt && mdl_q[owner].size() > 0) begin
          e = mdl_q[owner].pop_front();
          exp_q.push_back({3'(owner), e});
          done_pkt = e[8];
        end
        mdl_ptr = (owner + 1) % NREQ;
      end
    end while (owner >= 0);
  endtask

  function automatic bit drv_pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (drv_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock: handshake sampled mid-cycle, then queues, UART model and scoreboard after the edge.
  task automatic step();
    logic [NREQ-1:0] hs;
    logic [11:0] e;
    logic [8:0] popped;
    @(negedge clk);
    hs = req_ready & req_valid;
    check_output("ready_outside_grant", 32'(req_ready & ~grant), 32'(0));
    if (tx_busy) check_output("ready_while_busy", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < NREQ; i++) if (hs[i]) popped = drv_q[i].pop_front();
    if (uart_pend > 0) begin
      uart_pend--;
      if (uart_pend == 0) begin
        tx_busy   = 1'b1;
        uart_hold = busy_len;
      end
    end else if (tx_busy) begin
      uart_hold--;
      if (uart_hold == 0) tx_busy = 1'b0;
    end
    if (tx_start && !uart_never) uart_pend = busy_delay;
    check_output("start_latency", 32'(tx_start), 32'(hs != '0));
    if (tx_start) begin
      start_cycle = cycle;
      check_output("start_with_work", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("tx_data", 32'(tx_data), 32'(e[7:0]));
        check_output("grant_at_start", 32'(grant), 32'(1) << e[11:9]);
        last_tx = e[7:0];
      end
    end else begin
      check_output("tx_data_hold", 32'(tx_data), 32'(last_tx));
    end
    drive_reqs();
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (n < budget && (exp_q.size() > 0 || drv_pending() || grant != '0 || tx_busy)) begin
      step();
      n++;
    end
    check_output(tag, 32'(n < budget), 32'(1));
  endtask

  task automatic do_reset();
    #2;
    resetn    = 1'b0;
    req_valid = '1;
    #1;
    check_output("rst_grant", 32'(grant), 32'(0));
    check_output("rst_tx_start", 32'(tx_start), 32'(0));
    check_output("rst_tx_data", 32'(tx_data), 32'(0));
    check_output("rst_err", 32'(err_timeout), 32'(0));
    check_output("rst_ready", 32'(req_ready), 32'(0));
    for (int i = 0; i < NREQ; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    mdl_ptr    = 0;
    paused     = '0;
    last_tx    = 8'h00;
    tx_busy    = 1'b0;
    uart_pend  = 0;
    uart_hold  = 0;
    uart_never = 1'b0;
    drive_reqs();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic apply_stimulus();
    int n;
    int t0;
    do_reset();

    // Single requester two-byte packet.
    busy_delay = 1;
    busy_len   = 10;
    load_byte(2, 8'h41, 1'b0);
    load_byte(2, 8'h42, 1'b1);
    model_run();
    drive_reqs();
    run_until_idle(200, "r2_packet_drain");
    step();
    check_output("r2_grant_released", 32'(grant), 32'(0));

    // Two 3-byte packets are not interleaved; requester 0 first after reset.
    do_reset();
    load_packet(1, 3);
    load_packet(0, 3);
    model_run();
    drive_reqs();
    run_until_idle(400, "two_packet_drain");

    // Everyone presents single-byte packets: grant walks 0,1,2,3 and wraps.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      load_packet(i, 1);
      load_packet(i, 1);
    end
    model_run();
    drive_reqs();
    run_until_idle(800, "rr_wrap_drain");

    // Owner stalls mid-packet while requester 0 waits.
    load_packet(2, 3);
    model_run();
    drive_reqs();
    n = 0;
    while (exp_q.size() > 2 && n < 60) begin
      step();
      n++;
    end
    check_output("pause_first_byte", 32'(exp_q.size()), 32'(2));
    paused[2] = 1'b1;
    load_packet(0, 1);
    model_run();
    drive_reqs();
    for (int c = 0; c < 20; c++) begin
      step();
      check_output("pause_grant", 32'(grant), 32'(4'b0100));
      check_output("pause_no_start", 32'(tx_start), 32'(0));
    end
    paused = '0;
    drive_reqs();
    run_until_idle(400, "pause_drain");

    // Randomised packet mixes and UART timing.
    for (int r = 0; r < 4; r++) begin
      busy_delay = $urandom_range(1, 3);
      busy_len   = $urandom_range(1, 12);
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++) load_packet(i, $urandom_range(1, 3));
      end
      model_run();
      drive_reqs();
      run_until_idle(3000, "rand_drain");
    end

    // UART never acknowledges: timeout flag, then the next byte still goes out.
    uart_never = 1'b1;
    load_packet(1, 2);
    model_run();
    drive_reqs();
    check_output("err_before_timeout", 32'(err_timeout), 32'(0));
    start_cycle = -1;
    n = 0;
    while (start_cycle < 0 && n < 60) begin
      step();
      n++;
    end
    check_output("timeout_start_seen", 32'(start_cycle >= 0), 32'(1));
    t0 = start_cycle;
    n = 0;
    while (!err_timeout && n < 40) begin
      step();
      n++;
    end
    check_output("err_timeout_delay", 32'(cycle - t0), 32'(ACK_TIMEOUT));
    run_until_idle(200, "timeout_drain");
    check_output("err_sticky", 32'(err_timeout), 32'(1));
    uart_never = 1'b0;

    // Reset while requester 3 is mid-packet, then requester 1 must win.
    busy_delay = 1;
    busy_len   = 10;
    load_packet(3, 3);
    model_run();
    drive_reqs();
    n = 0;
    while (exp_q.size() > 2 && n < 60) begin
      step();
      n++;
    end
    step();
    step();
    step();
    check_output("r3_owner_mid", 32'(grant), 32'(4'b1000));
    do_reset();
    load_packet(3, 2);
    load_packet(1, 2);
    model_run();
    drive_reqs();
    run_until_idle(400, "post_reset_drain");
  endtask

  initial begin
    apply_stimulus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 15, giving the maximum cycles to wait for tx_busy to rise after a start pulse.
REQ-003 The block SHALL have port clk, input, 1, the single system clock (25 MHz); all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NREQ, where bit i means requester i presents a byte.
REQ-006 The block SHALL have port req_data, input, 8*NREQ, where bits [8i+7:8i] are the byte from requester i.
REQ-007 The block SHALL have port req_last, input, NREQ, where bit i marks the presented byte as the last byte of a packet.
REQ-008 The block SHALL have port req_ready, output, NREQ, where bit i means the byte from requester i is accepted this cycle.
REQ-009 The block SHALL have port grant, output, NREQ, a one-hot registered value naming the requester that owns the transmitter, all-zero when idle.
REQ-010 The block SHALL have port tx_data, output, 8, carrying the byte to the UART transmitter.
REQ-011 The block SHALL have port tx_start, output, 1, a one-cycle start pulse to the UART transmitter.
REQ-012 The block SHALL have port tx_busy, input, 1, the busy flag from the UART transmitter.
REQ-013 The block SHALL have port err_timeout, output, 1, a sticky flag set when tx_busy fails to rise within ACK_TIMEOUT cycles.

Function
REQ-014 The FSM SHALL have states IDLE, ARB, SEND, ACK and DONE.
REQ-015 IDLE SHALL go to ARB in the cycle after any req_valid bit is 1.
REQ-016 ARB SHALL use round-robin: search from (last_owner+1) mod NREQ upward with wrap, register the first valid requester into grant, update last_owner, and go to SEND, all in one cycle.
REQ-017 If no req_valid bit is set in ARB, the FSM SHALL return to IDLE with grant all-zero.
REQ-018 In SEND, req_ready[g] SHALL be combinationally (grant[g] & req_valid[g] & !tx_busy); all other req_ready bits SHALL be 0.
REQ-019 On req_ready[g] & req_valid[g], the block SHALL register req_data[g] into tx_data and req_last[g] into an internal last flag, assert tx_start for exactly the next cycle, and move to ACK.
REQ-020 In SEND with the owner's req_valid low, the FSM SHALL hold SEND and keep grant, since packets are never interleaved.
REQ-021 In ACK, a cycle counter SHALL start at 0 with tx_start; tx_busy=1 SHALL move the FSM to DONE.
REQ-022 If the ACK counter reaches ACK_TIMEOUT with tx_busy still 0, the block SHALL set err_timeout and move to DONE.
REQ-023 In DONE, the FSM SHALL wait for tx_busy=0; it SHALL then go to SEND if the last flag is 0, else to IDLE with grant cleared.
REQ-024 tx_data SHALL stay stable from the tx_start cycle until the next accepted byte.
REQ-025 Throughput SHALL be at most one byte per UART frame; accept-to-tx_start latency SHALL be 1 cycle.
REQ-026 Ownership SHALL change only at packet boundaries, so a single-byte packet (req_last=1 on its first byte) releases the grant after one byte.
REQ-027 Requesters SHALL keep req_valid, req_data and req_last stable until req_ready; the block SHALL not check this.
REQ-028 err_timeout SHALL clear only on reset.

Reset
REQ-029 resetn=0 SHALL immediately force IDLE, grant=0, tx_start=0, tx_data=0x00, err_timeout=0, the last flag=0, the ACK counter=0 and last_owner=NREQ-1, so requester 0 wins first.
REQ-030 req_ready SHALL be 0 throughout reset.
REQ-031 A reset mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from requester 0.
REQ-032 Reset release SHALL be synchronised externally; the first active edge may be the cycle after deassertion.

Verification
REQ-033 Scenario: only requester 2 sends 0x41,0x42(last); the UART model raises busy 1 cycle after start and holds it 10 cycles -> two tx_start pulses with tx_data 0x41 then 0x42, grant=0100 throughout, then grant=0000.
REQ-034 Scenario: requesters 0 and 1 each hold a 3-byte packet after reset -> all 3 bytes of requester 0 are sent, then all 3 of requester 1, with no interleaving.
REQ-035 Scenario: all 4 requesters continuously present single-byte packets -> grant order 0,1,2,3,0,1 with wrap from 3 to 0.
REQ-036 Scenario: the UART model never raises busy -> err_timeout=1 exactly ACK_TIMEOUT (15) cycles after tx_start, the FSM proceeds, and the next byte is still sent.
REQ-037 Scenario: resetn pulsed low while requester 3 is in DONE mid-packet -> outputs reset immediately; after release with requesters 1 and 3 valid, requester 0 priority restarts and requester 1 wins.
REQ-038 Scenario: the owner drops req_valid for 20 cycles mid-packet while requester 0 is valid -> grant unchanged, no tx_start, requester 0 is not served until the owner's last byte is sent.
